// File: rtl/rv_isa_pkg.sv
// Shared RV32I ISA definitions: formats, opcodes, instruction layouts,
// the canonical NOP and the legal immediate ranges per format.
package rv_isa_pkg;

    // Instruction format selector as presented on the request side.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } instr_fmt_e;

    // Base RV32I major opcodes.
    typedef enum logic [6:0] {
        OP_LOAD   = 7'h03,
        OP_IMM    = 7'h13,
        OP_AUIPC  = 7'h17,
        OP_STORE  = 7'h23,
        OP_REG    = 7'h33,
        OP_LUI    = 7'h37,
        OP_BRANCH = 7'h63,
        OP_JALR   = 7'h67,
        OP_JAL    = 7'h6F,
        OP_SYSTEM = 7'h73
    } opcode_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } r_type_t;

    typedef struct packed {
        logic [11:0] imm11_0;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } i_type_t;

    typedef struct packed {
        logic [6:0] imm11_5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] imm4_0;
        logic [6:0] opcode;
    } s_type_t;

    typedef struct packed {
        logic       imm12;
        logic [5:0] imm10_5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [3:0] imm4_1;
        logic       imm11;
        logic [6:0] opcode;
    } b_type_t;

    typedef struct packed {
        logic [19:0] imm31_12;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } u_type_t;

    typedef struct packed {
        logic       imm20;
        logic [9:0] imm10_1;
        logic       imm11;
        logic [7:0] imm19_12;
        logic [4:0] rd;
        logic [6:0] opcode;
    } j_type_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Legal signed immediate ranges (B and J are byte offsets, even only).
    localparam int IMM_IS_MIN = -2048;
    localparam int IMM_IS_MAX = 2047;
    localparam int IMM_B_MIN  = -4096;
    localparam int IMM_B_MAX  = 4094;
    localparam int IMM_J_MIN  = -1048576;
    localparam int IMM_J_MAX  = 1048574;

endpackage

// File: rtl/instr_pack.sv
// Combinational field-to-word packer: validates the immediate for the
// selected format and produces either the packed word or a NOP plus err.
module instr_pack
    import rv_isa_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        err_o
);

    logic signed [31:0] imm_s;
    r_type_t r_w;
    i_type_t i_w;
    s_type_t s_w;
    b_type_t b_w;
    u_type_t u_w;
    j_type_t j_w;
    logic [31:0] word;
    logic        bad;

    assign imm_s = $signed(imm_i);

    // Build every layout, then select by format and validate the immediate.
    always_comb begin
        r_w = '{funct7: funct7_i, rs2: rs2_i, rs1: rs1_i, funct3: funct3_i,
                rd: rd_i, opcode: opcode_i};
        i_w = '{imm11_0: imm_i[11:0], rs1: rs1_i, funct3: funct3_i,
                rd: rd_i, opcode: opcode_i};
        s_w = '{imm11_5: imm_i[11:5], rs2: rs2_i, rs1: rs1_i,
                funct3: funct3_i, imm4_0: imm_i[4:0], opcode: opcode_i};
        b_w = '{imm12: imm_i[12], imm10_5: imm_i[10:5], rs2: rs2_i,
                rs1: rs1_i, funct3: funct3_i, imm4_1: imm_i[4:1],
                imm11: imm_i[11], opcode: opcode_i};
        u_w = '{imm31_12: imm_i[31:12], rd: rd_i, opcode: opcode_i};
        j_w = '{imm20: imm_i[20], imm10_1: imm_i[10:1], imm11: imm_i[11],
                imm19_12: imm_i[19:12], rd: rd_i, opcode: opcode_i};

        word = NOP_INSTR;
        bad  = 1'b0;
        case (instr_fmt_e'(fmt_i))
            FMT_R: begin
                word = r_w;
            end
            FMT_I: begin
                word = i_w;
                bad  = (imm_s < IMM_IS_MIN) || (imm_s > IMM_IS_MAX);
            end
            FMT_S: begin
                word = s_w;
                bad  = (imm_s < IMM_IS_MIN) || (imm_s > IMM_IS_MAX);
            end
            FMT_B: begin
                word = b_w;
                bad  = (imm_s < IMM_B_MIN) || (imm_s > IMM_B_MAX) || imm_i[0];
            end
            FMT_U: begin
                word = u_w;
                bad  = (imm_i[11:0] != 12'd0);
            end
            FMT_J: begin
                word = j_w;
                bad  = (imm_s < IMM_J_MIN) || (imm_s > IMM_J_MAX) || imm_i[0];
            end
            default: begin
                bad = 1'b1;
            end
        endcase

        word_o = bad ? NOP_INSTR : word;
        err_o  = bad;
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs request fields into a 32-bit word, tags
// it with a wrapping instruction-memory byte address and buffers it in a
// 2-entry FIFO.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// an output word transfers on a rising edge where out_valid && out_ready.
// req_ready reflects only the registered occupancy (no pass-through when
// full), and the head entry is held stable while out_valid && !out_ready.
module instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_fmt,
    input  logic [6:0]        req_opcode,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              err_sticky
);

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } entry_t;

    // Entry 0 is always the head; entry 1 is only meaningful when count is 2.
    entry_t            ent0_q, ent0_d;
    entry_t            ent1_q, ent1_d;
    logic [1:0]        count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       idx_q, idx_d;
    logic              sticky_q, sticky_d;

    logic [31:0] pack_word;
    logic        pack_err;
    entry_t      new_ent;
    logic        push;
    logic        pop;

    instr_pack u_pack (
        .fmt_i    (req_fmt),
        .opcode_i (req_opcode),
        .rd_i     (req_rd),
        .rs1_i    (req_rs1),
        .rs2_i    (req_rs2),
        .funct3_i (req_funct3),
        .funct7_i (req_funct7),
        .imm_i    (req_imm),
        .word_o   (pack_word),
        .err_o    (pack_err)
    );

    assign req_ready  = (count_q < 2'd2);
    assign out_valid  = (count_q != 2'd0);
    assign out_instr  = out_valid ? ent0_q.instr : 32'd0;
    assign out_addr   = out_valid ? ent0_q.addr : '0;
    assign out_err    = out_valid & ent0_q.err;
    assign err_sticky = sticky_q;

    assign push    = req_valid && req_ready;
    assign pop     = out_valid && out_ready;
    assign new_ent = '{instr: pack_word, addr: addr_q, err: pack_err};

    // Next-state for FIFO occupancy, address counter and sticky error.
    always_comb begin
        ent0_d   = ent0_q;
        ent1_d   = ent1_q;
        count_d  = count_q;
        addr_d   = addr_q;
        idx_d    = idx_q;
        sticky_d = sticky_q;

        if (push && pop) begin
            // Only possible with one entry: the new word replaces the head.
            ent0_d = new_ent;
        end else if (pop) begin
            ent0_d  = ent1_q;
            count_d = count_q - 2'd1;
        end else if (push) begin
            if (count_q == 2'd0) begin
                ent0_d = new_ent;
            end else begin
                ent1_d = new_ent;
            end
            count_d = count_q + 2'd1;
        end

        if (push) begin
            if (idx_q == 32'(MEM_WORDS - 1)) begin
                idx_d  = 32'd0;
                addr_d = BASE_ADDR;
            end else begin
                idx_d  = idx_q + 32'd1;
                addr_d = addr_q + ADDR_W'(4);
            end
            if (pack_err) begin
                sticky_d = 1'b1;
            end
        end
    end

    // State register; reset and clear both flush everything.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ent0_q   <= '0;
            ent1_q   <= '0;
            count_q  <= 2'd0;
            addr_q   <= BASE_ADDR;
            idx_q    <= 32'd0;
            sticky_q <= 1'b0;
        end else begin
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            idx_q    <= idx_d;
            sticky_q <= sticky_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed vector table, backpressure, clear
// and randomized traffic against a behavioural model and expected queue.
module tb_instr_encoder;

    localparam int MEM_WORDS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_fmt = '0;
    logic [6:0]  req_opcode = '0;
    logic [4:0]  req_rd = '0;
    logic [4:0]  req_rs1 = '0;
    logic [4:0]  req_rs2 = '0;
    logic [2:0]  req_funct3 = '0;
    logic [6:0]  req_funct7 = '0;
    logic [31:0] req_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic        err_sticky;

    instr_encoder #(
        .ADDR_W    (32),
        .BASE_ADDR (32'h0),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_fmt    (req_fmt),
        .req_opcode (req_opcode),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_imm    (req_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .out_err    (out_err),
        .err_sticky (err_sticky)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    int n_checks = 0;
    int n_errors = 0;

    // {err, addr[31:0], instr[31:0]}
    logic [64:0] exp_q[$];
    logic [31:0] m_addr;
    int          m_idx;
    logic        m_sticky;
    logic        model_ok = 1'b0;
    logic        last_acc;
    logic        last_pop;
    logic [64:0] last_pop_word;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference encoding from the ISA bit layouts with plain shifts/masks.
    function automatic logic [32:0] model_encode(input logic [2:0] fmt, input logic [6:0] opc,
                                                 input logic [4:0] rd, input logic [4:0] rs1,
                                                 input logic [4:0] rs2, input logic [2:0] f3,
                                                 input logic [6:0] f7, input logic [31:0] imm);
        int          s;
        logic [31:0] u;
        logic [31:0] w;
        logic [31:0] regs;
        logic        bad;
        s    = $signed(imm);
        u    = imm;
        bad  = 1'b0;
        w    = 32'd0;
        regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | 32'(opc);
        case (fmt)
            3'd0: w = (32'(f7) << 25) | regs | (32'(rd) << 7);
            3'd1: begin
                bad = (s < -2048) || (s > 2047);
                w = ((u & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                    | (32'(rd) << 7) | 32'(opc);
            end
            3'd2: begin
                bad = (s < -2048) || (s > 2047);
                w = (((u >> 5) & 32'h7F) << 25) | regs | ((u & 32'h1F) << 7);
            end
            3'd3: begin
                bad = (s < -4096) || (s > 4094) || ((s % 2) != 0);
                w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | regs
                    | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7);
            end
            3'd4: begin
                bad = ((u % 4096) != 0);
                w = (u & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(opc);
            end
            3'd5: begin
                bad = (s < -1048576) || (s > 1048574) || ((s % 2) != 0);
                w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                    | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12)
                    | (32'(rd) << 7) | 32'(opc);
            end
            default: bad = 1'b1;
        endcase
        return bad ? {1'b1, 32'h0000_0013} : {1'b0, w};
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_addr   = 32'h0;
        m_idx    = 0;
        m_sticky = 1'b0;
        model_ok = 1'b1;
    endfunction

    // Compare DUT outputs against the model's current view.
    task automatic check_model();
        if (model_ok) begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("req_ready", 32'(req_ready), 32'(exp_q.size() < 2));
            chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
            if (exp_q.size() != 0) begin
                chk("head_instr", out_instr, exp_q[0][31:0]);
                chk("head_addr", out_addr, exp_q[0][63:32]);
                chk("head_err", 32'(out_err), 32'(exp_q[0][64]));
            end
        end
    endtask

    // One clock: check at negedge, decide transfers from the model, advance.
    task automatic step();
        logic        acc;
        logic        pop;
        logic [32:0] enc;
        @(negedge clk);
        check_model();
        acc = req_valid && (exp_q.size() < 2);
        pop = out_ready && (exp_q.size() > 0);
        last_acc = acc && !rst && !clear;
        last_pop = pop && !rst && !clear;
        if (last_pop) last_pop_word = exp_q[0];
        @(posedge clk);
        #1;
        if (rst || clear) begin
            model_reset();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                enc = model_encode(req_fmt, req_opcode, req_rd, req_rs1, req_rs2,
                                   req_funct3, req_funct7, req_imm);
                exp_q.push_back({enc[32], m_addr, enc[31:0]});
                if (enc[32]) m_sticky = 1'b1;
                if (m_idx == MEM_WORDS - 1) begin
                    m_idx  = 0;
                    m_addr = 32'h0;
                end else begin
                    m_idx  = m_idx + 1;
                    m_addr = m_addr + 32'd4;
                end
            end
        end
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        clear     = 1'b0;
        req_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_req(input logic [2:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm);
        req_fmt    = fmt;
        req_opcode = opc;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_funct3 = f3;
        req_funct7 = f7;
        req_imm    = imm;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    int boundary[13] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096,
                         -1048576, 1048574, 1048576, -1048577, -1048578};

    initial begin
        int          n_acc;
        int          budget;
        logic        seen_err;
        logic [31:0] pop_addrs[$];
        logic [31:0] exp_addrs[5];

        vecs[0]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h5,        32'h002081B3, 1'b0};
        vecs[1]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF00093, 1'b0};
        vecs[2]  = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,        32'h0020A423, 1'b0};
        vecs[3]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0};
        vecs[4]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
        vecs[5]  = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     32'h001000EF, 1'b0};
        vecs[6]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3,        32'h00000013, 1'b1};
        vecs[7]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 32'h80000093, 1'b0};
        vecs[8]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     32'h00000013, 1'b1};
        vecs[9]  = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd2047,     32'h7E20AFA3, 1'b0};
        vecs[10] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094,     32'h7E000FE3, 1'b0};
        vecs[11] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096,     32'h00000013, 1'b1};
        vecs[12] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00000, 32'h800000EF, 1'b0};
        vecs[13] = '{3'd6, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'd0,        32'h00000013, 1'b1};

        // ---- reset state ----
        reset_dut();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_sticky", 32'(err_sticky), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // ---- directed table, one word at a time ----
        seen_err = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            set_req(vecs[i].fmt, vecs[i].opc, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                    vecs[i].f3, vecs[i].f7, vecs[i].imm);
            req_valid = 1'b1;
            step();
            req_valid = 1'b0;
            seen_err = seen_err | vecs[i].exp_err;
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp_instr);
            chk($sformatf("vec%0d_err", i), 32'(out_err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_addr", i), out_addr, 32'((i % MEM_WORDS) * 4));
            chk($sformatf("vec%0d_sticky", i), 32'(err_sticky), 32'(seen_err));
            step();
        end

        // ---- backpressure: five words into a full FIFO, then drain ----
        reset_dut();
        out_ready = 1'b0;
        n_acc = 0;
        set_req(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1);
        req_valid = 1'b1;
        budget = 0;
        while (n_acc < 2 && budget < 10) begin
            step();
            budget++;
            if (last_acc) begin
                n_acc++;
                req_rd = 5'(n_acc);
            end
        end
        chk("bp_two_accepted", 32'(n_acc), 32'd2);
        for (int k = 0; k < 2; k++) begin
            step();
            if (last_acc) n_acc++;
            chk("bp_ready_low", 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        budget = 0;
        while ((n_acc < 5 || exp_q.size() != 0) && budget < 40) begin
            step();
            budget++;
            if (last_pop) pop_addrs.push_back(last_pop_word[63:32]);
            if (last_acc) begin
                n_acc++;
                req_rd = 5'(n_acc);
                if (n_acc == 5) req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        step();
        if (last_pop) pop_addrs.push_back(last_pop_word[63:32]);
        chk("bp_accepts", 32'(n_acc), 32'd5);
        chk("bp_pops", 32'(pop_addrs.size()), 32'd5);
        exp_addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0};
        for (int k = 0; k < 5 && k < pop_addrs.size(); k++) begin
            chk($sformatf("bp_addr%0d", k), pop_addrs[k], exp_addrs[k]);
        end

        // ---- clear with two buffered words ----
        reset_dut();
        out_ready = 1'b0;
        n_acc = 0;
        set_req(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3);
        req_valid = 1'b1;
        budget = 0;
        while (n_acc < 2 && budget < 10) begin
            step();
            budget++;
            if (last_acc) begin
                n_acc++;
                set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5);
            end
        end
        req_valid = 1'b0;
        chk("clr_pre_count", 32'(n_acc), 32'd2);
        chk("clr_pre_sticky", 32'(err_sticky), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_err_sticky", 32'(err_sticky), 32'd0);
        chk("clr_req_ready", 32'(req_ready), 32'd1);
        out_ready = 1'b1;
        set_req(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("clr_next_valid", 32'(out_valid), 32'd1);
        chk("clr_next_addr", out_addr, 32'h0);
        chk("clr_next_instr", out_instr, 32'h002081B3);
        step();

        // ---- randomized traffic against the model ----
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            if (!req_valid || last_acc) begin
                logic [31:0] imm;
                case ($urandom_range(0, 5))
                    0: imm = $urandom;
                    1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                    2: imm = 32'($urandom_range(0, 8200)) - 32'd4100;
                    3: imm = 32'(boundary[$urandom_range(0, 12)]);
                    4: imm = $urandom & 32'hFFFF_F000;
                    default: imm = 32'($urandom_range(0, 2097160)) - 32'd1048580;
                endcase
                set_req(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                        5'($urandom), 3'($urandom), 7'($urandom), imm);
                req_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            clear = ($urandom_range(0, 59) == 0);
            step();
        end
        clear = 1'b0;
        req_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
